// File: rtl/lfsr_seq_ctrl.sv
// Run controller for an external registered LFSR: seeds it, steps it once per accepted
// sample and streams N samples over valid/ready. Optional period detection: LFSR_CTRL_PERIOD_CHECK_EN.
module lfsr_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   seed,
    input  logic [COUNT_W-1:0] num_samples,
    input  logic               abort,
    output logic               lfsr_load,
    output logic [WIDTH-1:0]   lfsr_seed,
    output logic               lfsr_en,
    input  logic [WIDTH-1:0]   lfsr_out,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               done,
    output logic               seed_err,
    output logic [COUNT_W-1:0] sample_cnt,
    output logic               period_hit,
    output logic [COUNT_W-1:0] period_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   seed_q;
    logic [COUNT_W-1:0] num_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               done_zero_q;
    logic               seed_err_q;
    logic               handshake;
    logic               start_ok;
    logic               last_xfer;

    assign start_ok  = (state == IDLE) && start && (seed != '0) && (num_samples != '0);
    assign handshake = m_valid && m_ready;
    // cnt_q < num_q in RUN, so the increment cannot wrap.
    assign last_xfer = (cnt_q + COUNT_W'(1)) == num_q;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (handshake && last_xfer) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            seed_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            done_zero_q <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state       <= state_next;
            seed_err_q  <= (state == IDLE) && start && (seed == '0);
            done_zero_q <= (state == IDLE) && start && (seed != '0) && (num_samples == '0);
            if (start_ok) begin
                seed_q <= seed;
                num_q  <= num_samples;
                cnt_q  <= '0;
            end else if (handshake) begin
                cnt_q <= cnt_q + COUNT_W'(1);
            end
        end
    end

    assign lfsr_load  = (state == LOAD);
    assign lfsr_seed  = seed_q;
    assign m_valid    = (state == RUN);
    assign m_data     = m_valid ? lfsr_out : '0;
    assign lfsr_en    = handshake;
    assign busy       = (state != IDLE);
    // An abort during the DONE cycle suppresses the completion pulse.
    assign done       = ((state == DONE) && !abort) || done_zero_q;
    assign seed_err   = seed_err_q;
    assign sample_cnt = cnt_q;

`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    logic               period_seen_q;
    logic [COUNT_W-1:0] period_len_q;

    // The first transfer always carries the seed, so it is excluded from matching.
    assign period_hit = handshake && (lfsr_out == seed_q) && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_seen_q <= 1'b0;
            period_len_q  <= '0;
        end else if (start_ok) begin
            period_seen_q <= 1'b0;
            period_len_q  <= '0;
        end else if (period_hit && !period_seen_q) begin
            period_seen_q <= 1'b1;
            period_len_q  <= cnt_q;
        end
    end

    assign period_len = period_len_q;
`else
    assign period_hit = 1'b0;
    assign period_len = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: models the external LFSR and scoreboards every sample;
// period checks follow LFSR_CTRL_PERIOD_CHECK_EN.
module tb_lfsr_seq_ctrl;
    localparam int WIDTH   = 4;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   seed;
    logic [COUNT_W-1:0] num_samples;
    logic               abort;
    logic               lfsr_load;
    logic [WIDTH-1:0]   lfsr_seed;
    logic               lfsr_en;
    logic [WIDTH-1:0]   lfsr_out;
    logic [WIDTH-1:0]   m_data;
    logic               m_valid;
    logic               m_ready;
    logic               busy;
    logic               done;
    logic               seed_err;
    logic [COUNT_W-1:0] sample_cnt;
    logic               period_hit;
    logic [COUNT_W-1:0] period_len;

    int vectors     = 0;
    int miscompares = 0;
    int xfer_total  = 0;
    int done_total  = 0;
    int load_total  = 0;
    int hit_total   = 0;
    int hit_xfer    = 0;

    logic [WIDTH-1:0] exp_q[$];

    lfsr_seq_ctrl #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .num_samples(num_samples),
        .abort(abort), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en),
        .lfsr_out(lfsr_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .seed_err(seed_err), .sample_cnt(sample_cnt),
        .period_hit(period_hit), .period_len(period_len)
    );

    always #5 clk = ~clk;

    // Maximal-length 4-bit Fibonacci LFSR, x^4 + x^3 + 1 (period 15).
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[WIDTH-1] ^ s[WIDTH-2]};
    endfunction

    always @(posedge clk) begin
        if (reset)          lfsr_out <= '0;
        else if (lfsr_load) lfsr_out <= lfsr_seed;
        else if (lfsr_en)   lfsr_out <= lfsr_step(lfsr_out);
    end

    function automatic logic [30:0] all_outs();
        return {lfsr_load, lfsr_en, m_valid, busy, done, seed_err, period_hit,
                lfsr_seed, m_data, sample_cnt, period_len};
    endfunction

    // One clock: scoreboard the handshake at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        if (!reset && m_valid && m_ready) begin
            xfer_total++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_data: unexpected transfer m_data=%h, no sample expected", m_data);
            end else begin
                exp = exp_q.pop_front();
                if (m_data !== exp) begin
                    miscompares++;
                    $display("FAIL sb_data: transfer %0d m_data=%h, expected %h", xfer_total, m_data, exp);
                end
            end
        end
        if (done === 1'b1)      done_total++;
        if (lfsr_load === 1'b1) load_total++;
        if (period_hit === 1'b1) begin
            hit_total++;
            hit_xfer = xfer_total;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [WIDTH-1:0] s, input logic [COUNT_W-1:0] n,
                             input bit accepted);
        logic [WIDTH-1:0] v;
        seed        = s;
        num_samples = n;
        start       = 1'b1;
        if (accepted) begin
            v = s;
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back(v);
                v = lfsr_step(v);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        seed = '0; num_samples = '0;
        tick();
        tick();
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h, expected 0", all_outs());
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++; $display("FAIL idle_outputs: got %h, expected 0", all_outs());
        end
    endtask

    task automatic test_basic();
        int cyc;
        int bx = xfer_total;
        int bd = done_total;
        m_ready = 1'b1;
        start_run(4'h1, 8'd5, 1'b1);
        vectors++;
        if ({lfsr_load, busy} !== 2'b11) begin
            miscompares++; $display("FAIL load_at_t1: load,busy=%b, expected 11", {lfsr_load, busy});
        end
        tick();
        vectors++;
        if ({m_valid, m_data} !== {1'b1, 4'h1}) begin
            miscompares++; $display("FAIL first_sample: valid,data=%h, expected 11", {m_valid, m_data});
        end
        wait_done(20, cyc);
        vectors++;
        if (cyc != 5) begin
            miscompares++; $display("FAIL done_latency: done at T+%0d, expected T+7", cyc + 2);
        end
        vectors++;
        if ({busy, sample_cnt} !== {1'b1, 8'd5}) begin
            miscompares++; $display("FAIL done_state: busy=%b cnt=%0d, expected busy=1 cnt=5", busy, sample_cnt);
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++; $display("FAIL after_done: busy,done=%b, expected 00", {busy, done});
        end
        vectors++;
        if (xfer_total - bx != 5 || done_total - bd != 1) begin
            miscompares++;
            $display("FAIL basic_counts: xfers=%0d dones=%0d, expected 5 and 1", xfer_total - bx, done_total - bd);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int bx = xfer_total;
        logic [WIDTH-1:0] held = lfsr_step(lfsr_step(4'h1));
        m_ready = 1'b1;
        start_run(4'h1, 8'd5, 1'b1);
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({lfsr_en, m_valid, m_data} !== {1'b0, 1'b1, held}) begin
                miscompares++;
                $display("FAIL stall_%0d: en=%b valid=%b data=%h, expected en=0 valid=1 data=%h",
                         i, lfsr_en, m_valid, m_data, held);
            end
            tick();
        end
        m_ready = 1'b1;
        wait_done(20, cyc);
        vectors++;
        if (cyc != 3) begin
            miscompares++; $display("FAIL bp_done_latency: done at T+%0d, expected T+10", cyc + 7);
        end
        tick();
        vectors++;
        if (xfer_total - bx != 5 || sample_cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL bp_transfers: xfers=%0d cnt=%0d, expected 5", xfer_total - bx, sample_cnt);
        end
    endtask

    task automatic test_rejects();
        int bl = load_total;
        start_run(4'h0, 8'd5, 1'b0);
        vectors++;
        if ({seed_err, busy, lfsr_load} !== 3'b100) begin
            miscompares++; $display("FAIL seed_zero: err,busy,load=%b, expected 100", {seed_err, busy, lfsr_load});
        end
        tick();
        vectors++;
        if (seed_err !== 1'b0 || load_total != bl) begin
            miscompares++; $display("FAIL seed_err_pulse: err=%b loads=%0d, expected 0 and 0", seed_err, load_total - bl);
        end
        start_run(4'h3, 8'd0, 1'b0);
        vectors++;
        if ({done, busy, seed_err, sample_cnt} !== {3'b100, 8'd5}) begin
            miscompares++;
            $display("FAIL n_zero: done,busy,err=%b cnt=%0d, expected 100 cnt=5", {done, busy, seed_err}, sample_cnt);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++; $display("FAIL n_zero_pulse: done,busy=%b, expected 00", {done, busy});
        end
    endtask

    task automatic test_abort();
        int bx = xfer_total;
        int bd = done_total;
        m_ready = 1'b1;
        start_run(4'h1, 8'd10, 1'b1);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        vectors++;
        if ({busy, m_valid, done, sample_cnt} !== {3'b000, 8'd3}) begin
            miscompares++;
            $display("FAIL abort_state: busy,valid,done=%b cnt=%0d, expected 000 cnt=3", {busy, m_valid, done}, sample_cnt);
        end
        tick();
        tick();
        vectors++;
        if (xfer_total - bx != 3 || done_total != bd) begin
            miscompares++;
            $display("FAIL abort_counts: xfers=%0d dones=%0d, expected 3 and 0", xfer_total - bx, done_total - bd);
        end
    endtask

    task automatic test_reset_midrun();
        m_ready = 1'b1;
        start_run(4'h5, 8'd10, 1'b1);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++; $display("FAIL midrun_reset: outputs=%h, expected 0", all_outs());
        end
        reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_start_while_busy();
        int cyc;
        int bx = xfer_total;
        m_ready = 1'b1;
        start_run(4'h1, 8'd6, 1'b1);
        tick();
        seed = 4'h9; num_samples = 8'd2; start = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, lfsr_seed} !== {1'b1, 4'h1}) begin
            miscompares++; $display("FAIL busy_start_seed: busy=%b seed=%h, expected busy=1 seed=1", busy, lfsr_seed);
        end
        start = 1'b0;
        wait_done(20, cyc);
        vectors++;
        if (cyc != 4) begin
            miscompares++; $display("FAIL busy_start_len: done at T+%0d, expected T+8", cyc + 4);
        end
        tick();
        vectors++;
        if (xfer_total - bx != 6 || busy !== 1'b0) begin
            miscompares++; $display("FAIL busy_start_xfers: xfers=%0d busy=%b, expected 6 and 0", xfer_total - bx, busy);
        end
    endtask

    task automatic test_period();
        int cyc;
        int bx = xfer_total;
        int bh = hit_total;
        m_ready = 1'b1;
        start_run(4'h1, 8'd20, 1'b1);
        wait_done(40, cyc);
        tick();
        vectors++;
        if (xfer_total - bx != 20) begin
            miscompares++; $display("FAIL period_xfers: xfers=%0d, expected 20", xfer_total - bx);
        end
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
        vectors++;
        if (hit_total - bh != 1 || hit_xfer - bx != 16) begin
            miscompares++;
            $display("FAIL period_hit: hits=%0d at transfer %0d, expected 1 at 16", hit_total - bh, hit_xfer - bx);
        end
        vectors++;
        if (period_len !== 8'd15) begin
            miscompares++; $display("FAIL period_len: got %0d, expected 15", period_len);
        end
        start_run(4'h3, 8'd2, 1'b1);
        vectors++;
        if (period_len !== 8'd0) begin
            miscompares++; $display("FAIL period_clear: got %0d, expected 0", period_len);
        end
        wait_done(20, cyc);
        tick();
`else
        vectors++;
        if (hit_total != bh || period_len !== 8'd0) begin
            miscompares++;
            $display("FAIL period_tied: hits=%0d len=%0d, expected 0 and 0", hit_total - bh, period_len);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_rejects();
        test_abort();
        test_reset_midrun();
        test_start_while_busy();
        test_period();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL sb_leftover: %0d samples never transferred, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
